// File: rtl/vx_dcr_receiver.sv
// DCR write-bus responder: captures writes into a shadow bank and commits it
// atomically to the active bank the core consumes, with read-back and error counters.
module vx_dcr_receiver #(
  parameter int unsigned DCR_ADDR_WIDTH = 12,
  parameter int unsigned DCR_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 8,
  parameter logic [DCR_ADDR_WIDTH-1:0] BASE_ADDR = DCR_ADDR_WIDTH'(12'h001),
  parameter logic [NUM_REGS-1:0]       REQ_MASK  = NUM_REGS'(8'h07),
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write_valid,
  input  logic [DCR_ADDR_WIDTH-1:0] write_addr,
  input  logic [DCR_DATA_WIDTH-1:0] write_data,
  input  logic                      commit_req,
  output logic                      commit_ack,
  output logic                      cfg_ready,
  output logic                      active_valid,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [DCR_DATA_WIDTH-1:0] rd_data,
  output logic [15:0]               write_count,
  output logic [7:0]                bad_addr_count,
  output logic                      commit_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_ACK  = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  state_e                    state_q;
  logic [DCR_DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [DCR_DATA_WIDTH-1:0] active_q [NUM_REGS];
  logic [NUM_REGS-1:0]       written_mask_q;
  logic [NUM_REGS-1:0]       written_mask_d;
  logic                      cfg_ready_q;
  logic                      active_valid_q;
  logic                      commit_ack_q;
  logic                      commit_err_q;
  logic [15:0]               write_count_q;
  logic [7:0]                bad_addr_count_q;

  logic [DCR_ADDR_WIDTH-1:0] offset;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;
  logic                      wr_hit;
  logic                      wr_bad;

  // Address decode and next written-mask; a write's set wins over the commit clear.
  always_comb begin
    offset         = write_addr - BASE_ADDR;
    in_range       = (write_addr >= BASE_ADDR) &&
                     (offset < DCR_ADDR_WIDTH'(NUM_REGS));
    idx            = offset[IDX_W-1:0];
    wr_hit         = write_valid && in_range;
    wr_bad         = write_valid && !in_range;
    written_mask_d = written_mask_q;
    if (state_q == S_COPY) begin
      written_mask_d = '0;
    end
    if (wr_hit) begin
      written_mask_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      written_mask_q   <= '0;
      cfg_ready_q      <= 1'b0;
      active_valid_q   <= 1'b0;
      commit_ack_q     <= 1'b0;
      commit_err_q     <= 1'b0;
      write_count_q    <= '0;
      bad_addr_count_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      written_mask_q <= written_mask_d;
      cfg_ready_q    <= ((written_mask_d & REQ_MASK) == REQ_MASK);
      commit_ack_q   <= 1'b0;

      if (wr_hit) begin
        shadow_q[idx] <= write_data;
        if (write_count_q != 16'hFFFF) begin
          write_count_q <= write_count_q + 16'd1;
        end
      end
      if (wr_bad && (bad_addr_count_q != 8'hFF)) begin
        bad_addr_count_q <= bad_addr_count_q + 8'd1;
      end

      // Commit handshake; WAIT blocks a held request from committing twice.
      case (state_q)
        S_IDLE: begin
          if (commit_req) begin
            if (cfg_ready_q) begin
              state_q <= S_COPY;
            end else begin
              commit_err_q <= 1'b1;
            end
          end
        end
        S_COPY: begin
          for (int i = 0; i < int'(NUM_REGS); i++) begin
            active_q[i] <= shadow_q[i];
          end
          active_valid_q <= 1'b1;
          commit_ack_q   <= 1'b1;
          state_q        <= S_ACK;
        end
        S_ACK: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!commit_req) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_data        = (32'(rd_idx) < NUM_REGS) ? active_q[rd_idx] : '0;
  assign commit_ack     = commit_ack_q;
  assign cfg_ready      = cfg_ready_q;
  assign active_valid   = active_valid_q;
  assign commit_err     = commit_err_q;
  assign write_count    = write_count_q;
  assign bad_addr_count = bad_addr_count_q;

endmodule

// File: tb/tb_vx_dcr_receiver.sv
// Directed bench for vx_dcr_receiver: write capture, commit handshake,
// error reporting, reset abort and counter saturation.
module tb_vx_dcr_receiver;

  logic        clk;
  logic        reset;
  logic        write_valid;
  logic [11:0] write_addr;
  logic [31:0] write_data;
  logic        commit_req;
  logic        commit_ack;
  logic        cfg_ready;
  logic        active_valid;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic [15:0] write_count;
  logic [7:0]  bad_addr_count;
  logic        commit_err;

  int passed;
  int total;
  int acks;

  vx_dcr_receiver dut (
    .clk            (clk),
    .reset          (reset),
    .write_valid    (write_valid),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .commit_req     (commit_req),
    .commit_ack     (commit_ack),
    .cfg_ready      (cfg_ready),
    .active_valid   (active_valid),
    .rd_idx         (rd_idx),
    .rd_data        (rd_data),
    .write_count    (write_count),
    .bad_addr_count (bad_addr_count),
    .commit_err     (commit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    write_valid = 1'b1;
    write_addr  = a;
    write_data  = d;
    tick();
    write_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [2:0] i, input logic [31:0] exp);
    rd_idx = i;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    reset       = 1'b1;
    write_valid = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    commit_req  = 1'b0;
    rd_idx      = '0;
    tick();
    tick();

    check("rst_ack",   32'(commit_ack), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_avalid", 32'(active_valid), 32'd0);
    check("rst_wcnt",  32'(write_count), 32'd0);
    check("rst_bcnt",  32'(bad_addr_count), 32'd0);
    check("rst_err",   32'(commit_err), 32'd0);
    check_rd("rst_rd0", 3'd0, 32'd0);
    reset = 1'b0;
    tick();

    // Program the three required registers.
    wr(12'h001, 32'h8000_0000);
    check("ready_after1", 32'(cfg_ready), 32'd0);
    wr(12'h002, 32'h0);
    check("ready_after2", 32'(cfg_ready), 32'd0);
    wr(12'h003, 32'h1234);
    check("ready_after3", 32'(cfg_ready), 32'd1);
    check("wcnt_3", 32'(write_count), 32'd3);
    check("avalid_pre", 32'(active_valid), 32'd0);
    check_rd("rd0_pre", 3'd0, 32'd0);

    // Commit: ack two cycles after the request is sampled.
    commit_req = 1'b1;
    tick();
    check("ack_c1", 32'(commit_ack), 32'd0);
    tick();
    check("ack_c2", 32'(commit_ack), 32'd1);
    check_rd("rd0_commit", 3'd0, 32'h8000_0000);
    check_rd("rd2_commit", 3'd2, 32'h1234);
    check("ready_drop", 32'(cfg_ready), 32'd0);
    check("avalid_set", 32'(active_valid), 32'd1);
    commit_req = 1'b0;
    tick();
    check("ack_c3", 32'(commit_ack), 32'd0);
    tick();

    // Commit with only register 0 written.
    wr(12'h001, 32'h11);
    commit_req = 1'b1;
    tick();
    check("err_set", 32'(commit_err), 32'd1);
    check("err_noack", 32'(commit_ack), 32'd0);
    tick();
    tick();
    check("err_noack2", 32'(commit_ack), 32'd0);
    commit_req = 1'b0;
    tick();
    check_rd("err_rd0", 3'd0, 32'h8000_0000);
    tick();
    tick();
    tick();
    check("err_sticky", 32'(commit_err), 32'd1);

    // Out-of-range writes and the top in-range boundary.
    wr(12'h000, 32'hDEAD);
    wr(12'h009, 32'hBEEF);
    wr(12'hFFF, 32'hCAFE);
    check("bcnt_3", 32'(bad_addr_count), 32'd3);
    check("wcnt_4", 32'(write_count), 32'd4);
    check_rd("bad_rd0", 3'd0, 32'h8000_0000);
    check_rd("bad_rd1", 3'd1, 32'd0);
    check_rd("bad_rd2", 3'd2, 32'h1234);
    wr(12'h008, 32'h99);
    check("wcnt_top", 32'(write_count), 32'd5);
    check("bcnt_top", 32'(bad_addr_count), 32'd3);

    // Write on the COPY cycle with a held request.
    wr(12'h002, 32'h55);
    wr(12'h003, 32'h77);
    check("ready_copy", 32'(cfg_ready), 32'd1);
    commit_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      write_valid = (i == 1);
      write_addr  = 12'h002;
      write_data  = 32'hAA;
      tick();
      acks += int'(commit_ack);
    end
    write_valid = 1'b0;
    check("held_acks", 32'(acks), 32'd1);
    commit_req = 1'b0;
    tick();
    check_rd("copy_rd1", 3'd1, 32'h55);
    check_rd("copy_rd0", 3'd0, 32'h11);
    check_rd("copy_rd2", 3'd2, 32'h77);
    check_rd("copy_rd7", 3'd7, 32'h99);
    check("copy_ready", 32'(cfg_ready), 32'd0);
    wr(12'h001, 32'h22);
    check("mask1_ready_a", 32'(cfg_ready), 32'd0);
    wr(12'h003, 32'h33);
    check("mask1_ready_b", 32'(cfg_ready), 32'd1);
    check("wcnt_10", 32'(write_count), 32'd10);
    commit_req = 1'b1;
    tick();
    tick();
    check("ack_second", 32'(commit_ack), 32'd1);
    check_rd("shadow1_new", 3'd1, 32'hAA);
    commit_req = 1'b0;
    tick();
    tick();

    // Reset during COPY aborts the commit.
    wr(12'h001, 32'h1);
    wr(12'h002, 32'h2);
    wr(12'h003, 32'h3);
    commit_req = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("rcopy_ack", 32'(commit_ack), 32'd0);
    check("rcopy_avalid", 32'(active_valid), 32'd0);
    check("rcopy_ready", 32'(cfg_ready), 32'd0);
    check("rcopy_err", 32'(commit_err), 32'd0);
    check("rcopy_wcnt", 32'(write_count), 32'd0);
    check("rcopy_bcnt", 32'(bad_addr_count), 32'd0);
    check_rd("rcopy_rd1", 3'd1, 32'd0);
    reset = 1'b0;
    commit_req = 1'b0;
    tick();
    check("rcopy_ack2", 32'(commit_ack), 32'd0);
    check("rcopy_ready2", 32'(cfg_ready), 32'd0);

    // Reset during ACK drops the pulse.
    wr(12'h001, 32'h1);
    wr(12'h002, 32'h2);
    wr(12'h003, 32'h3);
    commit_req = 1'b1;
    tick();
    tick();
    check("rack_pre", 32'(commit_ack), 32'd1);
    reset = 1'b1;
    tick();
    check("rack_ack", 32'(commit_ack), 32'd0);
    check("rack_avalid", 32'(active_valid), 32'd0);
    check_rd("rack_rd0", 3'd0, 32'd0);
    reset = 1'b0;
    commit_req = 1'b0;
    tick();

    // Counter saturation.
    write_valid = 1'b1;
    write_addr  = 12'h001;
    write_data  = 32'h5;
    for (int i = 0; i < 70000; i++) tick();
    check("wcnt_sat", 32'(write_count), 32'hFFFF);
    write_addr = 12'h000;
    for (int i = 0; i < 300; i++) tick();
    write_valid = 1'b0;
    check("bcnt_sat", 32'(bad_addr_count), 32'hFF);
    check("wcnt_hold", 32'(write_count), 32'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vx_dcr_receiver.md
Name: vx_dcr_receiver

Overview:
- Responder end of the DCR write bus (write_valid / write_addr / write_data) that the testbench top drives into the GPU.
- Captures DCR writes into a shadow register bank and tracks which registers have been programmed.
- On a start request it commits the shadow bank atomically to an active bank that the core consumes, then acknowledges.
- Sits between the TB DCR driver and core reset release; also gives the verification checker a read-back port and error counters.

Parameters:
- DCR_ADDR_WIDTH, 12, DCR address width (matches VX_DCR_ADDR_WIDTH).
- DCR_DATA_WIDTH, 32, DCR data width (matches VX_DCR_DATA_WIDTH).
- NUM_REGS, 8, number of DCR registers implemented; range 1..32.
- BASE_ADDR, 12'h001, DCR address of register index 0.
- REQ_MASK, 8'h07, registers that must be written before commit is allowed; width NUM_REGS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- write_valid  in  1  DCR write strobe; no backpressure
- write_addr  in  DCR_ADDR_WIDTH  DCR write address
- write_data  in  DCR_DATA_WIDTH  DCR write data
- commit_req  in  1  request to copy shadow to active; level, held until commit_ack
- commit_ack  out  1  one-cycle pulse when commit completes
- cfg_ready  out  1  all REQ_MASK registers written since last commit/reset
- active_valid  out  1  active bank holds a committed configuration
- rd_idx  in  $clog2(NUM_REGS) (min 1)  read-back index into active bank
- rd_data  out  DCR_DATA_WIDTH  active[rd_idx], combinational
- write_count  out  16  accepted in-range writes, saturating at 16'hFFFF
- bad_addr_count  out  8  out-of-range writes, saturating at 8'hFF
- commit_err  out  1  sticky; commit requested while cfg_ready=0

Behaviour:
- Reset (sync, active-high): shadow and active banks = 0, written_mask = 0, state IDLE. All outputs low except rd_data, which reflects the zeroed active bank. Reset mid-commit aborts the commit; no ack is issued.
- Address decode: idx = write_addr - BASE_ADDR. A write is in range iff BASE_ADDR <= write_addr < BASE_ADDR + NUM_REGS.
  - In range, on the cycle write_valid=1: shadow[idx] <= write_data, written_mask[idx] <= 1, write_count +1 (saturating).
  - Out of range: no register change, bad_addr_count +1 (saturating).
- Repeated writes to the same register: last write wins; written_mask unchanged.
- cfg_ready = ((written_mask & REQ_MASK) == REQ_MASK), registered; it updates the cycle after the write.
- FSM:
  - IDLE -> COPY when commit_req=1 && cfg_ready=1.
  - In IDLE, if commit_req=1 && cfg_ready=0: set commit_err (sticky until reset), stay in IDLE.
  - COPY (one cycle): active <= shadow, written_mask <= 0, active_valid <= 1; go to ACK.
  - ACK: commit_ack=1 for exactly one cycle; go to WAIT.
  - WAIT: stay until commit_req=0, then go to IDLE. This prevents a double commit from a held request.
- Write on the COPY cycle: updates shadow only. Active gets the pre-write shadow value. written_mask for that index ends at 1 (the write's set takes priority over the clear).
- Writes during ACK/WAIT: normal shadow update.
- Latency: commit_req high in a cycle with cfg_ready=1 -> active updated at the next edge -> commit_ack high the following cycle, i.e. 2 cycles after the request is sampled.
- rd_data with rd_idx >= NUM_REGS returns 0.
- All counter arithmetic is unsigned; counters hold at max and never wrap.

Test Plan:
- Reset, then write 0x001=0x8000_0000, 0x002=0x0, 0x003=0x1234 -> cfg_ready=1 one cycle after the third write; write_count=3; active_valid=0; rd_data(idx0)=0.
- Commit after the above -> commit_ack pulses exactly 2 cycles after commit_req is sampled; rd_data(idx0)=0x8000_0000, rd_data(idx2)=0x1234; cfg_ready drops to 0; active_valid=1.
- Commit with only 0x001 written -> commit_err=1, no commit_ack, active bank unchanged; commit_err stays 1 until reset.
- Write 0x000, 0x009 and 0xFFF -> bad_addr_count=3, write_count and all banks unchanged.
- Write idx1=0xAA on the COPY cycle -> active[1] holds the old shadow value, shadow[1]=0xAA, written_mask[1]=1; commit_req held 5 cycles -> exactly one commit_ack.
- Assert reset during COPY/ACK -> no ack; all banks, counters and flags return to 0. Also: 70000 in-range writes -> write_count=0xFFFF.
